// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, widths and
// the wait-counter load helper.
package dmem_responder_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W_DEFAULT = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // The counter holds LATENCY-1 so the access fires on edge E+LATENCY.
  function automatic logic [3:0] latency_load(input int latency);
    return 4'(latency - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte synchronous write and registered synchronous read.
// Contents are never cleared; only the read register is updated on a read.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding memory responder: accepts a request, waits LATENCY cycles,
// performs the access in dmem_array and holds the response until it is taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_wr
);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              access_en;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    access_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d      = req_wen;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          be_d       = req_be;
          wait_cnt_d = latency_load(LATENCY);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          access_en = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with rst keeps an aborted store from touching memory on the reset edge.
  assign mem_wr_en = access_en & wen_q & ~rst;
  assign mem_rd_en = access_en & ~wen_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .wr_en (mem_wr_en),
    .rd_en (mem_rd_en),
    .addr  (addr_q),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // The array read register stays put until the next load, so gating by state suffices.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_wr    = resp_valid & wen_q;
  assign resp_rdata = (resp_valid && !wen_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed stores/loads on a LATENCY=2 instance,
// plus a LATENCY=1 instance checking back-to-back accept spacing.
module tb_dmem_responder;

  localparam int LAT0 = 2;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    int          accept;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          testCount = 0;
  int          failCount = 0;
  bit          monEn = 1'b0;
  exp_t        sb[$];
  exp_t        monE;
  logic        prevValid = 1'b0;
  logic [31:0] prevRdata = '0;
  logic        prevWr = 1'b0;

  logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_wr;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic [3:0]  req_be;

  logic        req_valid1, req_ready1, req_wen1, resp_valid1, resp_ready1, resp_wr1;
  logic [9:0]  req_addr1;
  logic [31:0] req_wdata1, resp_rdata1;
  logic [3:0]  req_be1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(10), .LATENCY(LAT0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_wr(resp_wr)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_wr(resp_wr1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    testCount++;
    failCount++;
    $display("[TB] FAIL %s: got timeout, expected event (cycle %0d)", name, cyc);
  endtask

  // Issue one request once the DUT is ready and queue its expected response.
  task automatic applyStimulus(input logic wen, input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] expRdata);
    exp_t e;
    for (int i = 0; i < 50 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      reportFail("req_ready_wait");
      return;
    end
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    e.wr     = wen;
    e.rdata  = expRdata;
    e.accept = cyc;
    sb.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) reportFail("drain");
  endtask

  // Monitor: latency on the first valid cycle, stability while held, data on handshake.
  always @(negedge clk) begin
    if (monEn) begin
      if (!resp_valid) begin
        checkOutput("rdata_zero_when_idle", resp_rdata, 32'h0);
      end else begin
        checkOutput("req_ready_low_in_resp", {31'b0, req_ready}, 32'h0);
        if (!prevValid) begin
          if (sb.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL unexpected_response: got rdata=%h, expected no response", resp_rdata);
          end else begin
            checkOutput("latency", cyc - sb[0].accept, LAT0);
          end
        end else begin
          checkOutput("hold_rdata", resp_rdata, prevRdata);
          checkOutput("hold_wr", {31'b0, resp_wr}, {31'b0, prevWr});
        end
        if (resp_ready && sb.size() != 0) begin
          monE = sb.pop_front();
          checkOutput("resp_wr", {31'b0, resp_wr}, {31'b0, monE.wr});
          checkOutput("resp_rdata", resp_rdata, monE.rdata);
        end
      end
      prevValid = resp_valid;
      prevRdata = resp_rdata;
      prevWr    = resp_wr;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, a1, hs;
    bit got, seenSt;
    req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1;
    req_valid1 = 0; req_wen1 = 0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0; resp_ready1 = 1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset_resp_wr", {31'b0, resp_wr}, 32'h0);
    rst = 1'b0;
    monEn = 1'b1;

    applyStimulus(1, 10'd7, 32'h0000_0000, 4'hF, 32'h0);
    applyStimulus(1, 10'd2, 32'hCAFE_F00D, 4'hF, 32'h0);
    applyStimulus(1, 10'd5, 32'hDEAD_BEEF, 4'hF, 32'h0);
    applyStimulus(1, 10'd5, 32'h0000_0011, 4'b0001, 32'h0);
    applyStimulus(0, 10'd5, 32'h0, 4'h0, 32'hDEAD_BE11);
    applyStimulus(1, 10'd2, 32'h1234_5678, 4'b0000, 32'h0);
    applyStimulus(0, 10'd2, 32'h0, 4'h0, 32'hCAFE_F00D);
    applyStimulus(1, 10'd9, 32'hFFFF_FFFF, 4'hF, 32'h0);
    applyStimulus(1, 10'd9, 32'h0000_0000, 4'b0110, 32'h0);
    applyStimulus(0, 10'd9, 32'h0, 4'h0, 32'hFF00_00FF);
    applyStimulus(1, 10'h3FF, 32'h0BAD_F00D, 4'hF, 32'h0);
    applyStimulus(1, 10'h000, 32'h1111_1111, 4'hF, 32'h0);
    applyStimulus(0, 10'h3FF, 32'h0, 4'h0, 32'h0BAD_F00D);
    applyStimulus(0, 10'h000, 32'h0, 4'h0, 32'h1111_1111);
    drain();

    // Response held off for 5 cycles while a second load waits on req_valid.
    resp_ready = 1'b0;
    applyStimulus(0, 10'd5, 32'h0, 4'h0, 32'hDEAD_BE11);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 10'd5;
    for (int i = 0; i < 10 && !resp_valid; i++) begin
      @(posedge clk); #1;
    end
    if (!resp_valid) reportFail("hold_resp_wait");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_req_ready", {31'b0, req_ready}, 32'h0);
      checkOutput("hold_resp_valid", {31'b0, resp_valid}, 32'h1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    checkOutput("after_hs_req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("after_hs_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    checkOutput("held_req_accepted", {31'b0, req_ready}, 32'h0);
    monE.wr = 1'b0; monE.rdata = 32'hDEAD_BE11; monE.accept = cyc;
    sb.push_back(monE);
    checkOutput("held_accept_spacing", cyc - hs, 32'd1);
    req_valid = 1'b0;
    drain();

    // Reset lands on the edge where the pending store would otherwise be performed.
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 10'd7; req_wdata = 32'h1234_5678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rst_wait_req_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_abort_req_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("rst_abort_resp_valid", {31'b0, resp_valid}, 32'h0);
    applyStimulus(0, 10'd7, 32'h0, 4'h0, 32'h0);
    applyStimulus(0, 10'd2, 32'h0, 4'h0, 32'hCAFE_F00D);
    drain();

    // LATENCY=1 instance: store then held load at the top address.
    req_valid1 = 1'b1; req_wen1 = 1'b1; req_addr1 = 10'h3FF; req_wdata1 = 32'hA5A5_A5A5; req_be1 = 4'hF;
    @(posedge clk); #1;
    a0 = cyc;
    checkOutput("l1_accept0", {31'b0, req_ready1}, 32'h0);
    req_wen1 = 1'b0; req_wdata1 = 32'h0;
    got = 0; seenSt = 0; a1 = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      logic pr;
      pr = req_ready1;
      @(posedge clk); #1;
      if (pr) begin
        a1 = cyc;
        got = 1;
      end else if (resp_valid1 && !seenSt) begin
        seenSt = 1;
        checkOutput("l1_store_latency", cyc - a0, 32'd1);
        checkOutput("l1_store_wr", {31'b0, resp_wr1}, 32'h1);
        checkOutput("l1_store_rdata", resp_rdata1, 32'h0);
      end
    end
    if (!seenSt) reportFail("l1_store_resp");
    if (!got) reportFail("l1_second_accept");
    else checkOutput("l1_accept_spacing", a1 - a0, 32'd3);
    req_valid1 = 1'b0;
    for (int i = 0; i < 10 && !resp_valid1; i++) begin
      @(posedge clk); #1;
    end
    if (!resp_valid1) reportFail("l1_load_resp");
    else begin
      checkOutput("l1_load_latency", cyc - a1, 32'd1);
      checkOutput("l1_load_rdata", resp_rdata1, 32'hA5A5_A5A5);
      checkOutput("l1_load_wr", {31'b0, resp_wr1}, 32'h0);
    end
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
